// File: rtl/sensor_alarm_ctrl.sv
// N-channel sensor qualifier and buzzer alarm sequencer.
// A sensor must stay high for DEBOUNCE_LEN enabled samples before its buzzer fires for ALARM_LEN cycles.
module sensor_alarm_ctrl #(
    parameter int N_CH         = 3,
    parameter int DEBOUNCE_LEN = 7,
    parameter int ALARM_LEN    = 31,
    parameter int PULSE_MODE   = 0,
    parameter int BEEP_HALF    = 4,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_CH-1:0] sensor,
    input  logic            ack,
    input  logic            evt_clr,
    output logic [N_CH-1:0] buzz,
    output logic            active,
    output logic [CH_W-1:0] chan,
    output logic [N_CH-1:0] evt
);

    localparam int DB_W = $clog2(DEBOUNCE_LEN + 1);
    localparam int AL_W = $clog2(ALARM_LEN + 1);
    localparam int BH_W = $clog2(BEEP_HALF + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LEN);
    localparam logic [AL_W-1:0] AL_LAST = AL_W'(ALARM_LEN);
    localparam logic [BH_W-1:0] BH_LAST = BH_W'(BEEP_HALF);

    typedef enum logic [1:0] {IDLE, QUAL, ALARM} state_t;

    state_t          state_reg, state_next;
    logic [CH_W-1:0] cand_reg, cand_next;
    logic [CH_W-1:0] chan_reg, chan_next;
    logic [DB_W-1:0] dbcnt_reg, dbcnt_next;
    logic [AL_W-1:0] alcnt_reg, alcnt_next;
    logic [BH_W-1:0] tone_cnt_reg, tone_cnt_next;
    logic            tone_on_reg, tone_on_next;
    logic [N_CH-1:0] buzz_reg, buzz_next;
    logic [N_CH-1:0] evt_reg, evt_next;
    logic            active_reg, active_next;
    logic [N_CH-1:0] cand_onehot;
    logic [CH_W-1:0] sel;
    logic            any;
    logic            alarm_enter, alarm_exit;

    // Lowest-index high sensor wins.
    always_comb begin
        sel = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (sensor[i]) sel = CH_W'(i);
        end
    end

    assign any = |sensor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cand_reg     <= '0;
            chan_reg     <= '0;
            dbcnt_reg    <= '0;
            alcnt_reg    <= '0;
            tone_cnt_reg <= '0;
            tone_on_reg  <= 1'b0;
            buzz_reg     <= '0;
            evt_reg      <= '0;
            active_reg   <= 1'b0;
        end else if (ena) begin
            state_reg    <= state_next;
            cand_reg     <= cand_next;
            chan_reg     <= chan_next;
            dbcnt_reg    <= dbcnt_next;
            alcnt_reg    <= alcnt_next;
            tone_cnt_reg <= tone_cnt_next;
            tone_on_reg  <= tone_on_next;
            buzz_reg     <= buzz_next;
            evt_reg      <= evt_next;
            active_reg   <= active_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cand_next     = cand_reg;
        dbcnt_next    = dbcnt_reg;
        alcnt_next    = alcnt_reg;
        tone_cnt_next = tone_cnt_reg;
        tone_on_next  = tone_on_reg;
        alarm_enter   = 1'b0;
        alarm_exit    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any) begin
                    cand_next = sel;
                    if (DEBOUNCE_LEN == 1) begin
                        alarm_enter = 1'b1;
                    end else begin
                        dbcnt_next = DB_W'(1);
                        state_next = QUAL;
                    end
                end
            end
            QUAL: begin
                if (!any) begin
                    dbcnt_next = '0;
                    state_next = IDLE;
                end else if (sel != cand_reg) begin
                    cand_next  = sel;
                    dbcnt_next = DB_W'(1);
                end else if (dbcnt_reg + DB_W'(1) == DB_LAST) begin
                    alarm_enter = 1'b1;
                end else begin
                    dbcnt_next = dbcnt_reg + DB_W'(1);
                end
            end
            ALARM: begin
                // Sensors are ignored here; only timeout or ack ends the alarm.
                if (alcnt_reg == AL_LAST || ack) begin
                    alarm_exit    = 1'b1;
                    alcnt_next    = '0;
                    tone_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    alcnt_next = alcnt_reg + AL_W'(1);
                    if (tone_cnt_reg == BH_LAST) begin
                        tone_cnt_next = BH_W'(1);
                        tone_on_next  = !tone_on_reg;
                    end else begin
                        tone_cnt_next = tone_cnt_reg + BH_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (alarm_enter) begin
            state_next    = ALARM;
            dbcnt_next    = '0;
            alcnt_next    = AL_W'(1);
            tone_cnt_next = BH_W'(1);
            tone_on_next  = 1'b1;
        end
    end

    always_comb begin
        cand_onehot = N_CH'(1) << cand_next;
        buzz_next   = buzz_reg;
        active_next = active_reg;
        chan_next   = (state_next == IDLE) ? chan_reg : cand_next;
        if (alarm_enter) begin
            buzz_next   = cand_onehot;
            active_next = 1'b1;
        end else if (alarm_exit) begin
            buzz_next   = '0;
            active_next = 1'b0;
        end else if (state_reg == ALARM && PULSE_MODE != 0) begin
            buzz_next = tone_on_next ? cand_onehot : '0;
        end
    end

    // A flag set on the alarm-entry edge beats a simultaneous clear.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_evt
            assign evt_next[gi] = (alarm_enter && cand_onehot[gi]) ? 1'b1 :
                                  (evt_clr ? 1'b0 : evt_reg[gi]);
        end
    endgenerate

    assign buzz   = buzz_reg;
    assign active = active_reg;
    assign chan   = chan_reg;
    assign evt    = evt_reg;

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// Scoreboard bench for sensor_alarm_ctrl: a steady-tone instance and a pulsed-tone instance.
module tb_sensor_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, ack, evt_clr;
    logic [2:0] sensor;
    logic [2:0] buzz, evt;
    logic       active;
    logic [1:0] chan;

    logic       ena_b, ack_b, evt_clr_b;
    logic [2:0] sensor_b;
    logic [2:0] buzz_b, evt_b;
    logic       active_b;
    logic [1:0] chan_b;

    sensor_alarm_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sensor(sensor), .ack(ack),
        .evt_clr(evt_clr), .buzz(buzz), .active(active), .chan(chan), .evt(evt)
    );

    sensor_alarm_ctrl #(.PULSE_MODE(1), .BEEP_HALF(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena_b), .sensor(sensor_b), .ack(ack_b),
        .evt_clr(evt_clr_b), .buzz(buzz_b), .active(active_b), .chan(chan_b), .evt(evt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         dut;
        int         tid;
        logic [8:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input bit d, input int tid, input logic [2:0] bz,
                        input logic ac, input logic [1:0] ch, input logic [2:0] ev);
        exp_t e;
        e.cyc = c;
        e.dut = d;
        e.tid = tid;
        e.exp = {bz, ac, ch, ev};
        q.push_back(e);
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: compare every expectation due at this edge, flag any that were skipped.
    exp_t       m_e;
    logic [8:0] m_got;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e = q.pop_front();
            m_got = m_e.dut ? {buzz_b, active_b, chan_b, evt_b} : {buzz, active, chan, evt};
            checks++;
            if (m_e.cyc < cyc) begin
                errors++;
                $display("FAIL t%0d_missed cyc=%0d expected {buzz,active,chan,evt}=%b never compared",
                         m_e.tid, m_e.cyc, m_e.exp);
            end else if (m_got !== m_e.exp) begin
                errors++;
                $display("FAIL t%0d_dut%0d cyc=%0d got {buzz,active,chan,evt}=%b want %b",
                         m_e.tid, m_e.dut, cyc, m_got, m_e.exp);
            end else begin
                $display("check t%0d dut%0d cyc=%0d {buzz,active,chan,evt}=%b ok",
                         m_e.tid, m_e.dut, cyc, m_got);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int b;
    int c;

    initial begin
        rst_n = 1'b0; ena = 1'b1; ack = 1'b0; evt_clr = 1'b0; sensor = 3'b000;
        ena_b = 1'b1; ack_b = 1'b0; evt_clr_b = 1'b0; sensor_b = 3'b000;
        wait_edge(3);
        rst_n = 1'b1;
        push(5, 1'b0, 0, 3'b000, 1'b0, 2'd0, 3'b000);
        push(5, 1'b1, 0, 3'b000, 1'b0, 2'd0, 3'b000);

        // T1: steady channel-1 alarm, full length, then evt_clr.
        wait_edge(6);
        b = cyc;
        push(b + 6,  1'b0, 1, 3'b000, 1'b0, 2'd1, 3'b000);
        push(b + 7,  1'b0, 1, 3'b010, 1'b1, 2'd1, 3'b010);
        push(b + 37, 1'b0, 1, 3'b010, 1'b1, 2'd1, 3'b010);
        push(b + 38, 1'b0, 1, 3'b000, 1'b0, 2'd1, 3'b010);
        push(b + 41, 1'b0, 1, 3'b000, 1'b0, 2'd1, 3'b000);
        sensor = 3'b010;
        wait_edge(b + 30); sensor = 3'b000;
        wait_edge(b + 40); evt_clr = 1'b1;
        wait_edge(b + 41); evt_clr = 1'b0;

        // T2: six samples only, no alarm.
        wait_edge(b + 45);
        b = cyc;
        push(b + 6, 1'b0, 2, 3'b000, 1'b0, 2'd2, 3'b000);
        push(b + 7, 1'b0, 2, 3'b000, 1'b0, 2'd2, 3'b000);
        push(b + 9, 1'b0, 2, 3'b000, 1'b0, 2'd2, 3'b000);
        sensor = 3'b100;
        wait_edge(b + 6); sensor = 3'b000;

        // T3: lower channel takes over candidacy, then acked.
        wait_edge(b + 12);
        b = cyc;
        push(b + 4,  1'b0, 3, 3'b000, 1'b0, 2'd2, 3'b000);
        push(b + 5,  1'b0, 3, 3'b000, 1'b0, 2'd0, 3'b000);
        push(b + 10, 1'b0, 3, 3'b000, 1'b0, 2'd0, 3'b000);
        push(b + 11, 1'b0, 3, 3'b001, 1'b1, 2'd0, 3'b001);
        push(b + 12, 1'b0, 3, 3'b000, 1'b0, 2'd0, 3'b001);
        sensor = 3'b100;
        wait_edge(b + 4);  sensor = 3'b101;
        wait_edge(b + 11); ack = 1'b1;
        wait_edge(b + 12); ack = 1'b0; sensor = 3'b000;

        // T4: ack at alarm cycle 5, re-qualify, evt_clr on the re-entry edge.
        wait_edge(b + 15);
        b = cyc;
        push(b + 7,  1'b0, 4, 3'b010, 1'b1, 2'd1, 3'b011);
        push(b + 11, 1'b0, 4, 3'b010, 1'b1, 2'd1, 3'b011);
        push(b + 12, 1'b0, 4, 3'b000, 1'b0, 2'd1, 3'b011);
        push(b + 18, 1'b0, 4, 3'b000, 1'b0, 2'd1, 3'b011);
        push(b + 19, 1'b0, 4, 3'b010, 1'b1, 2'd1, 3'b010);
        sensor = 3'b010;
        wait_edge(b + 11); ack = 1'b1;
        wait_edge(b + 12); ack = 1'b0;
        wait_edge(b + 18); evt_clr = 1'b1;
        wait_edge(b + 19); evt_clr = 1'b0;

        // T5: asynchronous reset mid-alarm, then full re-qualification.
        wait_edge(b + 22);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({buzz, active, chan, evt} !== 9'd0) begin
            errors++;
            $display("FAIL t5_async_rst got {buzz,active,chan,evt}=%b want 000000000",
                     {buzz, active, chan, evt});
        end else begin
            $display("check t5 async reset outputs cleared ok");
        end
        wait_edge(b + 24);
        rst_n = 1'b1;
        c = cyc;
        push(c + 6, 1'b0, 5, 3'b000, 1'b0, 2'd1, 3'b000);
        push(c + 7, 1'b0, 5, 3'b010, 1'b1, 2'd1, 3'b010);
        push(c + 9, 1'b0, 5, 3'b000, 1'b0, 2'd1, 3'b010);
        wait_edge(c + 8); ack = 1'b1; sensor = 3'b000;
        wait_edge(c + 9); ack = 1'b0;

        // T6: pulsed tone on the second instance with a 5-cycle ena freeze.
        wait_edge(c + 12);
        b = cyc;
        for (int off = 1; off <= 46; off++) begin
            int eff;
            int al;
            eff = (off <= 16) ? off : ((off <= 21) ? 16 : off - 5);
            al = eff - 6;
            if (al < 1)
                push(b + off, 1'b1, 6, 3'b000, 1'b0, 2'd0, 3'b000);
            else if (al <= 31)
                push(b + off, 1'b1, 6, (((al - 1) / 4) % 2 == 0) ? 3'b001 : 3'b000,
                     1'b1, 2'd0, 3'b001);
            else
                push(b + off, 1'b1, 6, 3'b000, 1'b0, 2'd0, 3'b001);
        end
        sensor_b = 3'b001;
        wait_edge(b + 16); ena_b = 1'b0;
        wait_edge(b + 21); ena_b = 1'b1;
        wait_edge(b + 30); sensor_b = 3'b000;

        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain %0d expectations left unchecked, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
